// File: rtl/toggle_period_meter_pkg.sv
// Shared definitions for the toggle period meter: default widths, the
// default abandon threshold and the measurement state encoding.
package toggle_period_meter_pkg;

   localparam int          TPM_W_DEFAULT       = 32;
   localparam logic [31:0] TPM_TIMEOUT_DEFAULT = 32'hFFFF_FFFE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } tpm_state_e;

endpackage

// File: rtl/toggle_period_meter_edge_detect.sv
// Edge detector for the toggle input: optional 2-flop synchronizer (TOGGLE_SYNC_EN),
// one history flop, and a pulse on every rising or falling transition.
module toggle_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic tog_in,
   output logic tog_edge
);

   logic tog_s;
   logic tog_q, tog_d;

`ifdef TOGGLE_SYNC_EN
   logic [1:0] sync_q, sync_d;

   assign sync_d = {sync_q[0], tog_in};
   assign tog_s  = sync_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= sync_d;
   end
`else
   assign tog_s = tog_in;
`endif

   assign tog_d = tog_s;

   // NOTE: flops take non-blocking assignments so every register samples
   // the pre-edge value of its neighbours, whatever the process order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tog_q <= 1'b0;
      else     tog_q <= tog_d;
   end

   assign tog_edge = tog_s ^ tog_q;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures the clk-cycle spacing between edges of tog_in and reports it with the
// matching divider freq value over a valid/ack handshake. Define TOGGLE_SYNC_EN
// when tog_in is asynchronous to clk.
module toggle_period_meter
   import toggle_period_meter_pkg::*;
#(
   parameter int             W       = TPM_W_DEFAULT,
   parameter logic [W-1:0]   TIMEOUT = W'(TPM_TIMEOUT_DEFAULT)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         tog_in,
   input  logic         meas_ack,
   output logic         meas_valid,
   output logic [W-1:0] meas_period,
   output logic [W-1:0] meas_freq,
   output logic         overrun,
   output logic         timeout
);

   localparam logic [W-1:0] ONE = W'(1);

   tpm_state_e   state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] period_q, period_d;
   logic [W-1:0] freq_q, freq_d;
   logic         valid_q, valid_d;
   logic         overrun_q, overrun_d;
   logic         timeout_q, timeout_d;
   logic         tog_edge;
   logic         ack_take;

   toggle_edge_detect u_edge (
      .clk      (clk),
      .rst      (rst),
      .tog_in   (tog_in),
      .tog_edge (tog_edge)
   );

   assign ack_take = meas_ack & valid_q;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it
      // unassigned and no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      freq_d    = freq_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      timeout_d = 1'b0;

      if (ack_take) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end

      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_d   = '0;
               state_d = ARM;
            end
            ARM: begin
               if (tog_edge) begin
                  cnt_d   = '0;
                  state_d = MEAS;
               end
            end
            MEAS: begin
               if (tog_edge) begin
                  // cnt never exceeds TIMEOUT, so cnt+1 cannot wrap.
                  period_d = cnt_q + ONE;
                  freq_d   = cnt_q;
                  valid_d  = 1'b1;
                  cnt_d    = '0;
                  if (valid_q && !meas_ack) overrun_d = 1'b1;
               end else if (cnt_q == TIMEOUT) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = ARM;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         freq_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         freq_q    <= freq_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
      end
   end

   assign meas_valid  = valid_q;
   assign meas_period = period_q;
   assign meas_freq   = freq_q;
   assign overrun     = overrun_q;
   assign timeout     = timeout_q;

endmodule

// File: doc/toggle_period_meter.md
Name: toggle_period_meter

Overview:
- Receive-side counterpart to the slow-clock divider: measures the spacing, in `clk` cycles, between consecutive edges of an incoming toggle signal.
- Reports the spacing and the equivalent divider `freq` setting that would produce it, through a valid/ack handshake.
- Sits beside the generation-tick logic as a self-check and calibration aid for the board step rate.

Parameters:
- W, 32, width of the counter and result fields
- TIMEOUT, 32'hFFFF_FFFE, number of idle cycles in MEASURE without an edge before the measurement is abandoned (must be < 2^W-1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  measurement enable
- tog_in  in  1  toggle signal under measurement (e.g. a divider's slow-clock output)
- meas_ack  in  1  consumer accepts the current result
- meas_valid  out  1  result available, held until acked
- meas_period  out  W  edge spacing in clk cycles
- meas_freq  out  W  meas_period-1, the divider freq value that yields this spacing
- overrun  out  1  sticky: a result was overwritten before being acked
- timeout  out  1  one-cycle pulse when TIMEOUT expires

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=0, tog_q=0, meas_valid=0, meas_period=0, meas_freq=0, overrun=0, timeout=0, sync flops=0.
- Edge detection:
  - tog_s is tog_in after the sync stages (see Optional Feature).
  - tog_q is tog_s registered once.
  - edge = tog_s XOR tog_q. Both rising and falling edges count.
- States:
  - IDLE: cnt held at 0. en=1 moves to ARM next cycle.
  - ARM: waits for the first edge. On edge: cnt<=0, go to MEASURE; no result is produced.
  - MEASURE: cnt increments by 1 every cycle.
    - On edge: meas_period<=cnt+1, meas_freq<=cnt, meas_valid<=1, cnt<=0, stay in MEASURE.
    - If cnt==TIMEOUT and no edge: timeout pulses 1 cycle, cnt<=0, go to ARM.
  - en=0 in any state: go to IDLE next cycle, cnt<=0. meas_* and overrun are retained. An edge in that same cycle is ignored.
- Result latency: meas_valid and the result regs update on the clock edge that samples edge=1. Edges spaced S cycles apart give meas_period=S.
- Handshake:
  - meas_ack with meas_valid=1 clears meas_valid next cycle and clears overrun.
  - meas_ack with meas_valid=0 is ignored.
- Simultaneous events:
  - New result and ack in the same cycle: the new result is loaded, meas_valid stays 1, overrun is not set.
  - New result while meas_valid=1 and no ack: result overwritten, overrun<=1, overrun holds until the next ack.
- Arithmetic:
  - cnt is W bits and never exceeds TIMEOUT, so cnt+1 never wraps.
  - meas_freq is the pre-increment cnt; no subtraction logic is needed.
- Reset mid-MEASURE aborts immediately. The first post-reset edge only re-arms.

Optional Feature:
- Macro: TOGGLE_SYNC_EN.
- Defined: tog_in passes through a 2-flop synchronizer before tog_s. Edge detection is delayed by 2 cycles. Measured spacing is unchanged.
- Undefined: tog_s = tog_in directly. tog_in must be synchronous to clk.

Decomposition:
- Shared package:
  - W default
  - state enum IDLE=2'd0, ARM=2'd1, MEAS=2'd2
  - TIMEOUT default constant
- Sub-module toggle_edge_detect:
  - Contents: optional synchronizer, tog_q register, edge output.
  - Ports: clk, rst, tog_in, edge.

Test Plan:
- en=1, tog_in toggling every 5 cycles (divider freq=4): first edge yields no result; every later edge gives meas_period=5, meas_freq=4, meas_valid=1; ack each result, overrun stays 0.
- Slow spacing 1000 cycles, then change to 3 mid-stream: consecutive results 1000 then 3, no glitch values.
- TIMEOUT=20 override, one edge then tog_in static: timeout pulses exactly 21 cycles after the edge-sample cycle, state returns to ARM, next edge gives no result.
- Two results with no ack (spacing 6): overrun=1, meas_period=6. Ack gives meas_valid=0 and overrun=0. Result plus ack in the same cycle leaves valid=1, overrun=0.
- en dropped mid-MEASURE: IDLE next cycle, results retained. Re-enable: the first edge only arms.
- Async rst asserted between clk edges mid-measure: all outputs 0 immediately. With TOGGLE_SYNC_EN, meas_valid rises 2 cycles later than without it, with identical meas_period.
